// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pipe_pkg;

  // Bubble instruction: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default PC loaded on reset
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Contents of one IF/ID slot
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  localparam int unsigned IF_ID_W = $bits(if_id_t);

  // Instruction addresses are always word aligned. Masking uses every
  // input bit, so the dropped low bits do not show up as unused logic.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction slot for decode.
// Latency: 1 cycle from i_slot to o_slot on an advancing edge.
// Backpressure: i_stall holds the slot; i_flush (priority) turns it into a bubble.
//
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_stall        : hold current slot contents
//   i_flush        : replace slot with a bubble, keeping pc/pc4
//   i_slot         : packed if_id_t captured on an advancing edge
//   o_slot         : packed if_id_t currently held
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [IF_ID_W-1:0] i_slot,
  output logic [IF_ID_W-1:0] o_slot
);

  if_id_t slot_d;
  if_id_t slot_q;
  if_id_t slot_in;

  assign slot_in = if_id_t'(i_slot);

  // Two implicit slot states: BUBBLE (valid=0) and VALID.
  // Flush forces BUBBLE, advance forces VALID, stall keeps whatever is held.
  // pc/pc4 are left alone on a flush; only valid and instr are scrubbed.
  always_comb begin
    slot_d = slot_q;
    if (i_flush) begin
      slot_d.valid = 1'b0;
      slot_d.instr = NOP_INSTR;
    end else if (!i_stall) begin
      slot_d = slot_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q.valid <= 1'b0;
      slot_q.pc    <= 32'h0;
      slot_q.pc4   <= 32'h0;
      slot_q.instr <= NOP_INSTR;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign o_slot = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select, imem address, IF/ID capture.
// Latency: 1 cycle (combinational imem read, word captured at the edge ending the cycle).
// Backpressure: i_stall holds PC and IF/ID; i_redirect overrides stall and flushes IF/ID.
//
// Ports:
//   i_clk, i_rst_n        : clock (rising edge), asynchronous active-low reset
//   i_stall               : hazard unit hold
//   i_redirect            : taken branch/jump from EX
//   i_redirect_pc         : redirect target (low two bits ignored)
//   i_imem_rdata          : instruction word for o_imem_addr, same cycle
//   o_imem_addr           : byte address to instruction memory (pc_q truncated)
//   o_pc_if               : current fetch PC
//   o_id_pc/o_id_pc4      : PC and PC+4 of the instruction in IF/ID
//   o_id_instr/o_id_valid : IF/ID instruction and its valid flag
// Optional macro FETCH_PERF_CNT_EN adds o_fetch_cnt and o_bubble_cnt.
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = rv_pipe_pkg::RESET_PC,
  parameter int unsigned IMEM_AW   = 14,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  input  logic [31:0]        i_imem_rdata,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [31:0]        o_pc_if,
  output logic [31:0]        o_id_pc,
  output logic [31:0]        o_id_pc4,
  output logic [31:0]        o_id_instr,
  output logic               o_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_bubble_cnt
`endif
);

  logic [31:0]        pc_d;
  logic [31:0]        pc_q;
  logic [31:0]        pc_plus4;
  logic               advance;
  if_id_t             slot_in;
  logic [IF_ID_W-1:0] slot_out;
  if_id_t             slot_view;

  // Redirect wins over stall; an advance happens only when neither is set.
  assign advance  = !i_redirect && !i_stall;

  // 32-bit modulo add: 0xFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (i_redirect) begin
      pc_d = align_pc(i_redirect_pc);
    end else if (!i_stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Upper PC bits do not address memory but still travel down the pipe.
  assign o_imem_addr = pc_q[IMEM_AW-1:0];
  assign o_pc_if     = pc_q;

  // Slot offered to IF/ID on an advancing edge.
  always_comb begin
    slot_in       = '0;
    slot_in.valid = 1'b1;
    slot_in.pc    = pc_q;
    slot_in.pc4   = pc_plus4;
    slot_in.instr = i_imem_rdata;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stall (i_stall),
    .i_flush (i_redirect),
    .i_slot  (slot_in),
    .o_slot  (slot_out)
  );

  assign slot_view  = if_id_t'(slot_out);
  assign o_id_valid = slot_view.valid;
  assign o_id_pc    = slot_view.pc;
  assign o_id_pc4   = slot_view.pc4;
  assign o_id_instr = slot_view.instr;

`ifdef FETCH_PERF_CNT_EN
  // Every edge is either an advance or a bubble (redirect or stall).
  logic [31:0] fetch_cnt_d;
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_d;
  logic [31:0] bubble_cnt_q;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (advance) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`else
  // Without performance counters the advance qualifier has no consumer.
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule
